// File: rtl/detect_log_pkg.sv
// Shared defaults for the detection event logger.
// Sizes for the counter, timestamps and FIFO depth.
package detect_log_pkg;

  localparam int CNT_W_DEF   = 8;
  localparam int STAMP_W_DEF = 8;
  localparam int DEPTH_DEF   = 4;
  localparam int PTR_W       = $clog2(DEPTH_DEF);

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered read port.
// Pointers carry an extra wrap bit to split full from empty.
module sync_fifo
  import detect_log_pkg::*;
#(
  parameter int W     = STAMP_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         rd_valid,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wp;
  logic [AW:0]  rp;
  logic [W-1:0] mem [DEPTH];
  logic         do_pop;
  logic         do_push;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);

  // a pop frees the slot, so a full FIFO still accepts a push
  assign do_pop  = pop & ~empty & ~rst & ~flush;
  assign do_push = push & (~full | do_pop) & ~rst & ~flush;

  // storage write, no reset needed on the array
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wp[AW-1:0]] <= wr_data;
    end
  end

  // pointer and read-port update; flush keeps last rd_data
  always_ff @(posedge clk) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (flush) begin
      wp       <= '0;
      rp       <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= do_pop;
      if (do_pop) begin
        rd_data <= mem[rp[AW-1:0]];
        rp      <= rp + 1'b1;
      end
      if (do_push) begin
        wp <= wp + 1'b1;
      end
    end
  end

endmodule

// File: rtl/detect_event_logger.sv
// Counts and timestamps detector events into a FIFO.
// Define DEC_EDGE_EN to count only rising edges of dec.
module detect_event_logger
  import detect_log_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int STAMP_W = STAMP_W_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dec,
  input  logic               clr,
  input  logic               rd_en,
  output logic [STAMP_W-1:0] rd_data,
  output logic               rd_valid,
  output logic               empty,
  output logic               full,
  output logic [CNT_W-1:0]   count,
  output logic               overflow
);

  logic [STAMP_W-1:0] timer;
  logic               ev;
  logic               acc;
  logic               drop;

`ifdef DEC_EDGE_EN
  logic dec_q;

  // previous dec sample for edge qualification
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_q <= 1'b0;
    end else begin
      dec_q <= dec;
    end
  end

  assign ev = dec & ~dec_q;
`else
  assign ev = dec;
`endif

  // clr discards the event entirely
  assign acc  = ev & ~clr;
  // full with a pop in the same cycle still has room
  assign drop = acc & full & ~rd_en;

  // free-running stamp timer, only reset clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // saturating event counter
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (acc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  // sticky overflow on dropped stamps
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .W     (STAMP_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (clr),
    .push     (acc),
    .pop      (rd_en),
    .wr_data  (timer),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .full     (full),
    .empty    (empty)
  );

endmodule

// File: tb/tb_detect_event_logger.sv
// Bench for detect_event_logger: directed scenarios plus
// random traffic against a queue-based reference model.
module tb_detect_event_logger;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic dec = 1'b0;
  logic clr = 1'b0;
  logic rd_en = 1'b0;

  logic [7:0] rd_data;
  logic [7:0] count;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic       overflow;

  logic [3:0] rd_data_s;
  logic [2:0] count_s;
  logic       rd_valid_s;
  logic       empty_s;
  logic       full_s;
  logic       overflow_s;

  detect_event_logger #(
    .CNT_W(8), .STAMP_W(8), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .dec(dec), .clr(clr),
    .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .empty(empty), .full(full),
    .count(count), .overflow(overflow)
  );

  detect_event_logger #(
    .CNT_W(3), .STAMP_W(4), .DEPTH(DEPTH)
  ) dut_s (
    .clk(clk), .rst(rst), .dec(dec), .clr(clr),
    .rd_en(rd_en), .rd_data(rd_data_s),
    .rd_valid(rd_valid_s), .empty(empty_s),
    .full(full_s), .count(count_s),
    .overflow(overflow_s)
  );

  int checks = 0;
  int errors = 0;

  int q[$];
  int m_cnt = 0;
  int m_k = 0;
  int m_rdd = 0;
  bit m_ovf = 0;
  bit m_rdv = 0;
  bit m_prev = 0;

  task automatic model_update();
    bit ev;
    bit pop;
    bit fb;
    if (rst) begin
      q.delete();
      m_cnt = 0; m_ovf = 0; m_k = 0;
      m_prev = 0; m_rdd = 0; m_rdv = 0;
    end else begin
`ifdef DEC_EDGE_EN
      ev = dec && !m_prev;
`else
      ev = dec;
`endif
      m_prev = dec;
      if (clr) begin
        q.delete();
        m_cnt = 0; m_ovf = 0; m_rdv = 0;
      end else begin
        pop = rd_en && (q.size() > 0);
        fb = (q.size() == DEPTH);
        m_rdv = pop;
        if (pop) m_rdd = q.pop_front();
        if (ev) begin
          m_cnt++;
          if (!fb || pop) q.push_back(m_k);
          else m_ovf = 1;
        end
      end
      m_k++;
    end
  endtask

  function automatic int ecnt(int w);
    int mx;
    mx = (1 << w) - 1;
    return (m_cnt > mx) ? mx : m_cnt;
  endfunction

  task automatic step(input bit d, input bit r,
                      input bit c, input bit s);
    dec = d; rd_en = r; clr = c; rst = s;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    checks++;
    if (count !== 8'd0) begin
      errors++;
      $display("FAIL reset_count got %0d want 0", count);
    end
    checks++;
    if ({empty, full, overflow, rd_valid} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags got %b want 1000",
               {empty, full, overflow, rd_valid});
    end
    checks++;
    if (rd_data !== 8'd0) begin
      errors++;
      $display("FAIL reset_rd_data got %0d want 0", rd_data);
    end
    step(0, 0, 0, 0);
  endtask

  task automatic test_single_pulses();
    do_reset();
    for (int k = 0; k < 10; k++) step(k == 3 || k == 7, 0, 0, 0);
    checks++;
    if (count !== 8'd2) begin
      errors++;
      $display("FAIL single_count got %0d want 2", count);
    end
    step(0, 1, 0, 0);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'd3) begin
      errors++;
      $display("FAIL single_rd0 got v=%b d=%0d want v=1 d=3",
               rd_valid, rd_data);
    end
    step(0, 1, 0, 0);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'd7) begin
      errors++;
      $display("FAIL single_rd1 got v=%b d=%0d want v=1 d=7",
               rd_valid, rd_data);
    end
    step(0, 1, 0, 0);
    checks++;
    if (rd_valid !== 1'b0 || empty !== 1'b1 || rd_data !== 8'd7) begin
      errors++;
      $display("FAIL single_after got v=%b e=%b d=%0d want 0 1 7",
               rd_valid, empty, rd_data);
    end
  endtask

  task automatic test_overflow();
    int exp[4] = '{2, 4, 6, 8};
    do_reset();
    for (int k = 0; k <= 10; k++) begin
      step(k >= 2 && k % 2 == 0, 0, 0, 0);
      if (k == 6) begin
        checks++;
        if (full !== 1'b0) begin
          errors++;
          $display("FAIL ovf_full_k6 got %b want 0", full);
        end
      end
      if (k == 8) begin
        checks++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
          errors++;
          $display("FAIL ovf_k8 got f=%b o=%b want 1 0",
                   full, overflow);
        end
      end
    end
    checks++;
    if (overflow !== 1'b1 || count !== 8'd5) begin
      errors++;
      $display("FAIL ovf_k10 got o=%b c=%0d want 1 5",
               overflow, count);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'(exp[i])) begin
        errors++;
        $display("FAIL ovf_rd%0d got v=%b d=%0d want v=1 d=%0d",
                 i, rd_valid, rd_data, exp[i]);
      end
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL ovf_empty got %b want 1", empty);
    end
  endtask

  task automatic test_full_corner();
    int exp[4] = '{4, 6, 8, 20};
    do_reset();
    for (int k = 0; k <= 20; k++) begin
      step((k >= 2 && k <= 8 && k % 2 == 0) || k == 20,
           k == 20, 0, 0);
    end
    checks++;
    if ({rd_valid, full, overflow} !== 3'b110 ||
        rd_data !== 8'd2) begin
      errors++;
      $display("FAIL corner got v=%b f=%b o=%b d=%0d want 1 1 0 2",
               rd_valid, full, overflow, rd_data);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0);
      checks++;
      if (rd_data !== 8'(exp[i])) begin
        errors++;
        $display("FAIL corner_rd%0d got %0d want %0d",
                 i, rd_data, exp[i]);
      end
    end
  endtask

  task automatic test_run();
`ifdef DEC_EDGE_EN
    int exp[$] = '{10};
`else
    int exp[$] = '{10, 11, 12};
`endif
    do_reset();
    for (int k = 0; k <= 13; k++) step(k >= 10 && k <= 12, 0, 0, 0);
    checks++;
    if (count !== 8'(exp.size())) begin
      errors++;
      $display("FAIL run_count got %0d want %0d",
               count, exp.size());
    end
    foreach (exp[i]) begin
      step(0, 1, 0, 0);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'(exp[i])) begin
        errors++;
        $display("FAIL run_rd%0d got v=%b d=%0d want v=1 d=%0d",
                 i, rd_valid, rd_data, exp[i]);
      end
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL run_empty got %b want 1", empty);
    end
  endtask

  task automatic test_sat_wrap();
    do_reset();
    for (int k = 0; k <= 16; k++) step(k <= 14 && k % 2 == 0, 1, 0, 0);
    step(1, 0, 0, 0);
    checks++;
    if (count_s !== 3'd7 || count !== 8'd9) begin
      errors++;
      $display("FAIL sat_count got s=%0d b=%0d want 7 9",
               count_s, count);
    end
    step(0, 1, 0, 0);
    checks++;
    if (rd_data_s !== 4'd1 || rd_data !== 8'd17) begin
      errors++;
      $display("FAIL wrap_stamp got s=%0d b=%0d want 1 17",
               rd_data_s, rd_data);
    end
    for (int k = 19; k <= 27; k++) step(k % 2 == 1, 0, 0, 0);
    checks++;
    if (overflow_s !== 1'b1 || full_s !== 1'b1) begin
      errors++;
      $display("FAIL sat_ovf got o=%b f=%b want 1 1",
               overflow_s, full_s);
    end
    step(1, 1, 1, 0);
    checks++;
    if (count_s !== 3'd0 || count !== 8'd0 ||
        {empty_s, overflow_s, rd_valid_s} !== 3'b100) begin
      errors++;
      $display("FAIL clr got c=%0d e=%b o=%b v=%b want 0 1 0 0",
               count_s, empty_s, overflow_s, rd_valid_s);
    end
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    checks++;
    if (rd_data_s !== 4'd14 || rd_data !== 8'd30) begin
      errors++;
      $display("FAIL clr_timer got s=%0d b=%0d want 14 30",
               rd_data_s, rd_data);
    end
  endtask

  task automatic test_random();
    bit d, r, c, s;
    logic [3:0] ef;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      d = ($urandom_range(99) < 45);
      r = ($urandom_range(99) < 40);
      c = ($urandom_range(99) < 3);
      s = ($urandom_range(199) < 2);
      step(d, r, c, s);
      ef = {m_rdv, q.size() == 0, q.size() == DEPTH, m_ovf};
      checks++;
      if ({rd_valid, empty, full, overflow} !== ef ||
          count !== 8'(ecnt(8)) || rd_data !== 8'(m_rdd)) begin
        errors++;
        $display("FAIL rand_big cyc=%0d got %b c=%0d d=%0d want %b c=%0d d=%0d",
                 i, {rd_valid, empty, full, overflow}, count,
                 rd_data, ef, ecnt(8), m_rdd & 255);
      end
      checks++;
      if ({rd_valid_s, empty_s, full_s, overflow_s} !== ef ||
          count_s !== 3'(ecnt(3)) || rd_data_s !== 4'(m_rdd)) begin
        errors++;
        $display("FAIL rand_small cyc=%0d got %b c=%0d d=%0d want %b c=%0d d=%0d",
                 i, {rd_valid_s, empty_s, full_s, overflow_s},
                 count_s, rd_data_s, ef, ecnt(3), m_rdd & 15);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_pulses();
    test_overflow();
    test_full_corner();
    test_run();
    test_sat_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
